// File: rtl/mmr_decoder.sv
// BAR0 MMR responder: routes one request at a time to a device by base field.
// Optional saturating error counter on err_cnt when MMR_DECODER_ERRCNT_EN is defined.
module mmr_decoder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BASE_W    = 6,
  parameter int DEV_W     = ADDR_W - BASE_W,
  parameter int DEV_COUNT = 16,
  parameter int TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
`ifdef MMR_DECODER_ERRCNT_EN
  output logic [15:0]               err_cnt,
`endif
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [DEV_COUNT-1:0]      dev_req,
  output logic                      dev_wr,
  output logic [DEV_W-1:0]          dev_addr,
  output logic [DATA_W-1:0]         dev_wdata,
  input  logic [DEV_COUNT-1:0]      dev_ack,
  input  logic [DEV_COUNT*DATA_W-1:0] dev_rdata
);

  localparam int IDX_W = (DEV_COUNT > 1) ? $clog2(DEV_COUNT) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DEV_COUNT-1:0] dev_req_q, dev_req_d;
  logic                 dev_wr_q, dev_wr_d;
  logic [DEV_W-1:0]     dev_addr_q, dev_addr_d;
  logic [DATA_W-1:0]    dev_wdata_q, dev_wdata_d;

  logic [BASE_W-1:0]    base;
  logic                 mapped;
  logic                 ack_sel;
  logic [DATA_W-1:0]    rdata_sel;

  assign base   = req_addr[ADDR_W-1 -: BASE_W];
  assign mapped = {{(32-BASE_W){1'b0}}, base} < DEV_COUNT;

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < DEV_COUNT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel   = dev_ack[i];
        rdata_sel = dev_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    dev_req_d   = '0;
    dev_wr_d    = dev_wr_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          idx_d       = base[IDX_W-1:0];
          dev_wr_d    = req_wr;
          dev_addr_d  = req_addr[DEV_W-1:0];
          dev_wdata_d = req_wdata;
          if (mapped) begin
            state_d   = ISSUE;
            dev_req_d = DEV_COUNT'(1) << base[IDX_W-1:0];
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = req_wr ? '0 : ERR_DATA;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // an ack on the expiry cycle still completes the access
        if (ack_sel) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = dev_wr_q ? '0 : rdata_sel;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = dev_wr_q ? '0 : ERR_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      dev_req_q   <= '0;
      dev_wr_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dev_req_q   <= dev_req_d;
      dev_wr_q    <= dev_wr_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
    end
  end

  // ready is forced low while reset is held so no request slips in
  assign req_ready = req_ready_q & ~rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dev_req   = dev_req_q;
  assign dev_wr    = dev_wr_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;

`ifdef MMR_DECODER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_entry;

  assign err_entry = (state_q != RESP) && (state_d == RESP) && rsp_err_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_entry && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  // no error counter in this build
`endif

endmodule

// File: tb/tb_mmr_decoder.sv
// Randomized bench for mmr_decoder with an event-time reference model.
// Define MMR_DECODER_ERRCNT_EN to also check err_cnt.
module tb_mmr_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_wr;
  logic [15:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [15:0]  dev_req, dev_ack;
  logic         dev_wr;
  logic [9:0]   dev_addr;
  logic [31:0]  dev_wdata;
  logic [511:0] dev_rdata;
`ifdef MMR_DECODER_ERRCNT_EN
  logic [15:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  mmr_decoder dut (
`ifdef MMR_DECODER_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dev_req(dev_req), .dev_wr(dev_wr), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic        exp_req_ready, exp_rsp_valid, exp_rsp_err;
  logic [31:0] exp_rsp_rdata;
  logic [15:0] exp_dev_req;
  logic        exp_dev_wr;
  logic [9:0]  exp_dev_addr;
  logic [31:0] exp_dev_wdata;
  logic [15:0] exp_errcnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(exp_req_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(exp_rsp_err));
      chk("dev_req", 64'(dev_req), 64'(exp_dev_req));
      if (exp_dev_req != 16'h0) begin
        chk("dev_wr", 64'(dev_wr), 64'(exp_dev_wr));
        chk("dev_addr", 64'(dev_addr), 64'(exp_dev_addr));
        chk("dev_wdata", 64'(dev_wdata), 64'(exp_dev_wdata));
      end
`ifdef MMR_DECODER_ERRCNT_EN
      chk("err_cnt", 64'(err_cnt), 64'(exp_errcnt));
`endif
    end
  end

  task automatic quiet_inputs();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    dev_ack   = '0;
  endtask

  task automatic idle_expect();
    exp_req_ready = 1'b1;
    exp_rsp_valid = 1'b0;
    exp_dev_req   = '0;
  endtask

  task automatic idle(input int n);
    quiet_inputs();
    idle_expect();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  // Model: response cycle R (relative to accept) follows from ack delay d:
  // unmapped -> 1; ack within the 255-cycle window -> 2+d; else -> 257.
  task automatic run_txn(
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  int          ack_d,
    input  int          s,
    input  bit          stray,
    input  bit          use_fix,
    input  logic [31:0] fix_val,
    output logic [15:0] o_req,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output int          o_lat,
    output logic [9:0]  o_addr,
    output logic        o_wr
  );
    int          idx, r, h;
    bit          mapped, acked, early;
    logic [15:0] oh;
    logic [31:0] rsp_d;
    logic        rsp_e;
    idx    = int'(addr[15:10]);
    mapped = idx < 16;
    acked  = mapped && ack_d >= 1 && ack_d <= 255;
    early  = 1'($urandom % 2);
    oh     = mapped ? (16'h1 << idx) : 16'h0;
    if (!mapped)    r = 1;
    else if (acked) r = 2 + ack_d;
    else            r = 257;
    h     = r + s;
    rsp_d = (wr || acked) ? 32'h0 : 32'hDEAD_BEEF;
    rsp_e = !acked;
    o_req = '0; o_rdata = '0; o_err = 1'b0;
    o_lat = -1; o_addr = '0; o_wr = 1'b0;
    for (int k = 0; k <= h; k++) begin
      if (k == 0) begin
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
      end else begin
        req_valid = 1'($urandom % 2);
        req_wr    = 1'($urandom % 2);
        req_addr  = 16'($urandom);
        req_wdata = $urandom;
      end
      for (int j = 0; j < 16; j++) dev_rdata[j*32 +: 32] = $urandom;
      dev_ack = '0;
      if (mapped && ack_d > 0 && k == 1 + ack_d) begin
        dev_ack = oh;
        if (use_fix) dev_rdata[idx*32 +: 32] = fix_val;
        if (acked && !wr) rsp_d = dev_rdata[idx*32 +: 32];
      end
      if (mapped && early && k == 1) dev_ack = dev_ack | oh;
      if (stray && k == 3) dev_ack[(idx + 2) % 16] = 1'b1;
      rsp_ready = (k < r) ? 1'($urandom % 2) : (k == h);
      exp_req_ready = (k == 0);
      exp_dev_req   = (mapped && k == 1) ? oh : 16'h0;
      exp_dev_wr    = wr;
      exp_dev_addr  = addr[9:0];
      exp_dev_wdata = wdata;
      exp_rsp_valid = (k >= r);
      if (k == r) begin
        exp_rsp_rdata = rsp_d;
        exp_rsp_err   = rsp_e;
        if (rsp_e && exp_errcnt != 16'hFFFF) exp_errcnt = exp_errcnt + 16'd1;
      end
      @(negedge clk);
      o_req = o_req | dev_req;
      if (k == 1) begin
        o_addr = dev_addr;
        o_wr   = dev_wr;
      end
      if (rsp_valid && o_lat < 0) begin
        o_lat   = k;
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
      end
      @(posedge clk); #1;
    end
    quiet_inputs();
    idle_expect();
  endtask

  task automatic abort_test();
    logic [15:0] oh;
    oh = 16'h0040;
    for (int k = 0; k <= 6; k++) begin
      quiet_inputs();
      exp_req_ready = (k == 0);
      exp_dev_req   = (k == 1) ? oh : 16'h0;
      exp_rsp_valid = 1'b0;
      exp_dev_wr    = 1'b0;
      exp_dev_addr  = 10'h025;
      exp_dev_wdata = 32'h0;
      if (k == 0) begin
        req_valid = 1'b1;
        req_addr  = 16'h1825;
      end
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        rst           = 1'b0;
        dev_ack       = oh;
        exp_req_ready = 1'b1;
        exp_rsp_rdata = '0;
        exp_rsp_err   = 1'b0;
        exp_errcnt    = '0;
      end
      @(negedge clk);
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  logic [15:0] o_req;
  logic [31:0] o_rdata;
  logic        o_err, o_wr;
  logic [9:0]  o_addr;
  int          o_lat;

  initial begin
    quiet_inputs();
    dev_rdata     = '0;
    rst           = 1'b1;
    exp_req_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
    exp_dev_req   = '0;
    exp_dev_wr    = 1'b0;
    exp_dev_addr  = '0;
    exp_dev_wdata = '0;
    exp_errcnt    = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_dev_addr", 64'(dev_addr), 64'h0);
    chk("rst_dev_wdata", 64'(dev_wdata), 64'h0);
    chk("rst_dev_wr", 64'(dev_wr), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;

    run_txn(1'b1, 16'h0C10, 32'hA5A5_0001, 2, 0, 1'b0, 1'b0, 32'h0,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("wr_dev_req", 64'(o_req), 64'h0008);
    chk("wr_dev_addr", 64'(o_addr), 64'h010);
    chk("wr_dev_wr", 64'(o_wr), 64'h1);
    chk("wr_err", 64'(o_err), 64'h0);
    chk("wr_rdata", 64'(o_rdata), 64'h0);
    chk("wr_lat", 64'(o_lat), 64'd4);
    idle(1);

    run_txn(1'b0, 16'h1404, 32'h0, 1, 0, 1'b0, 1'b1, 32'h1234_5678,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("rd_rdata", 64'(o_rdata), 64'h1234_5678);
    chk("rd_err", 64'(o_err), 64'h0);
    chk("rd_lat", 64'(o_lat), 64'd3);

    run_txn(1'b0, 16'h4400, 32'h0, 1, 0, 1'b0, 1'b0, 32'h0,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("unm_dev_req", 64'(o_req), 64'h0);
    chk("unm_err", 64'(o_err), 64'h1);
    chk("unm_rdata", 64'(o_rdata), 64'hDEAD_BEEF);
    chk("unm_lat", 64'(o_lat), 64'd1);
`ifdef MMR_DECODER_ERRCNT_EN
    chk("unm_err_cnt", 64'(err_cnt), 64'd1);
`endif

    run_txn(1'b0, 16'h0800, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("to_err", 64'(o_err), 64'h1);
    chk("to_rdata", 64'(o_rdata), 64'hDEAD_BEEF);
    chk("to_lat", 64'(o_lat), 64'd257);

    run_txn(1'b0, 16'h0400, 32'h0, 1, 10, 1'b0, 1'b1, 32'h0BAD_F00D,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("stall_rdata", 64'(o_rdata), 64'h0BAD_F00D);
    chk("stall_lat", 64'(o_lat), 64'd3);

    run_txn(1'b0, 16'h1C00, 32'h0, 255, 0, 1'b0, 1'b1, 32'hCAFE_0007,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("edge_err", 64'(o_err), 64'h0);
    chk("edge_rdata", 64'(o_rdata), 64'hCAFE_0007);
    chk("edge_lat", 64'(o_lat), 64'd257);

    abort_test();
    run_txn(1'b1, 16'h1800, 32'h5555_AAAA, 1, 0, 1'b0, 1'b0, 32'h0,
            o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
    chk("post_rst_req", 64'(o_req), 64'h0040);
    chk("post_rst_err", 64'(o_err), 64'h0);
    chk("post_rst_lat", 64'(o_lat), 64'd3);

    for (int t = 0; t < 40; t++) begin
      int idx, sel, d;
      logic [15:0] a;
      idx = ($urandom % 5 == 0) ? 16 + int'($urandom % 48)
                                : int'($urandom % 16);
      a   = {6'(idx), 10'($urandom)};
      sel = int'($urandom % 20);
      if (sel == 0)      d = 0;
      else if (sel == 1) d = 255;
      else if (sel == 2) d = 256;
      else               d = 1 + int'($urandom % 6);
      run_txn(1'($urandom % 2), a, $urandom, d, int'($urandom % 4),
              1'($urandom % 2), 1'b0, 32'h0,
              o_req, o_rdata, o_err, o_lat, o_addr, o_wr);
      idle(int'($urandom % 3));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmr_decoder.md
Name: mmr_decoder

Overview:
- Responder end of the BAR0 memory-mapped register path. Accepts single-beat MMR read/write requests from the PCIe BAR0 initiator and routes each one by base-address field to one of DEV_COUNT register devices (SYS, SCC, IC, EVR, … LOAD).
- Collects the device acknowledge and read data and returns exactly one response per request.
- Sits between the BAR0 bridge and the per-device MMR slaves.
- Supports one outstanding transaction, with a per-access timeout.

Parameters:
- ADDR_W, 16, MMR address width (equal to BAR0 address width).
- DATA_W, 32, MMR data width.
- BASE_W, 6, device-select field width; the field is addr[ADDR_W-1 -: BASE_W].
- DEV_W, ADDR_W-BASE_W (10), in-device offset width; the offset is addr[DEV_W-1:0].
- DEV_COUNT, 16, number of attached devices (indices 0..DEV_COUNT-1).
- TIMEOUT, 255, WAIT cycles before an error response; must be ≥1.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  initiator request valid
- req_ready  out  1  decoder can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  unmapped device or timeout
- dev_req  out  DEV_COUNT  one-hot single-cycle strobe to selected device
- dev_wr  out  1  write flag to devices
- dev_addr  out  DEV_W  in-device offset
- dev_wdata  out  DATA_W  write data to devices
- dev_ack  in  DEV_COUNT  per-device completion strobe
- dev_rdata  in  DEV_COUNT*DATA_W  flattened read data; device i occupies slice [i*DATA_W +: DATA_W]

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; req_ready=1 from the first cycle after rst deasserts (0 while rst=1); rsp_valid=0, rsp_rdata=0, rsp_err=0, dev_req=0, dev_wr=0, dev_addr=0, dev_wdata=0; timer=0.
- Reset mid-operation aborts the transaction: no response is issued, and a late dev_ack after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE (req_ready=1):
  - A request is accepted on req_valid&req_ready.
  - On acceptance, latch wr, idx=base field, offset and wdata, and drop req_ready.
  - idx ≥ DEV_COUNT → RESP with rsp_err=1; rsp_rdata=ERR_DATA for reads, 0 for writes; no dev_req is issued.
  - Otherwise → ISSUE.
- ISSUE:
  - dev_req[idx]=1 for exactly this one cycle.
  - dev_wr, dev_addr and dev_wdata become valid this cycle and are held stable until the FSM returns to IDLE.
  - Clear timer, then → WAIT.
- WAIT:
  - dev_ack is sampled only in WAIT, so the earliest usable ack is the cycle after dev_req.
  - dev_ack[idx]=1 → capture the dev_rdata slice idx (reads) or 0 (writes) into rsp_rdata, set rsp_err=0, → RESP.
  - dev_ack bits for other indices are ignored.
  - Otherwise timer+1. When timer==TIMEOUT-1 with no ack → rsp_err=1, rsp_rdata=ERR_DATA for reads and 0 for writes, → RESP.
  - If the ack arrives in the same cycle as timeout expiry, the ack wins.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, drop rsp_valid and → IDLE; req_ready=1 the next cycle.
- Latency (device acking one cycle after dev_req): accept at T, dev_req at T+1, ack at T+2, rsp_valid at T+3.
- Timer width is clog2(TIMEOUT+1) and it never wraps.

Optional Feature:
- Macro MMR_DECODER_ERRCNT_EN.
- Defined:
  - Adds output err_cnt, 16 bits, reset 0.
  - Increments by 1 on each entry to RESP with rsp_err=1 (both unmapped and timeout cases).
  - Saturates at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Write addr 16'h0C10, wdata 32'hA5A5_0001; device 3 acks 2 cycles after dev_req → dev_req=16'h0008 for one cycle, dev_addr=10'h010, dev_wr=1; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 16'h1404; device 5 acks 1 cycle after dev_req with slice 32'h1234_5678 → rsp_rdata=32'h1234_5678, rsp_err=0, rsp_valid at T+3.
- Read addr 16'h4400 (idx 17) → no dev_req; rsp_err=1, rsp_rdata=32'hDEAD_BEEF; err_cnt=1 with macro defined.
- Read device 2 with no ack, while dev_ack[4] pulses (stray ack) → stray ack ignored; rsp_valid exactly 255 WAIT cycles later, rsp_err=1, rsp_rdata=32'hDEAD_BEEF.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0; accepted on the 11th cycle, req_ready=1 the next cycle.
- Assert rst for 1 cycle while in WAIT, then pulse dev_ack for the pending device → no rsp_valid; req_ready=1 after reset; next request handled normally.
